// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 3-sample majority bit decisions, start-glitch rejection,
// and a one-entry valid/ready output register carrying parity/framing flags and an overrun pulse.
module uart_rx_cfg #(
  parameter int CLOCK_RATE  = 1_843_200,
  parameter int BAUD_RATE   = 115_200,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  rx,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  // state   | meaning
  // IDLE    | line idle, waiting for rxs low
  // START   | start bit, rejected if it votes high
  // DATA    | shifting data bits, LSB first
  // PAR     | parity bit check
  // STOP    | stop bit(s); word completes at the last stop decision
  // RECOVER | framing error seen, wait for line high

  localparam int CLK_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int MID         = CLK_PER_BIT / 2;
  localparam int CW          = $clog2(CLK_PER_BIT);
  localparam int BW          = $clog2(DATA_WIDTH + 1);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(MID);
  localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PAR     = 3'd3,
    STOP    = 3'd4,
    RECOVER = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  state_t                  state_q, state_d;
  logic [CW-1:0]           clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic                    stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [1:0]              samp_q, samp_d;
  logic                    perr_q, perr_d;
  logic                    ferr_q, ferr_d;

  logic                    vote, decide, bit_end;
  logic                    done, word_ferr;

  logic                    m_valid_q;
  logic [DATA_WIDTH-1:0]   m_data_q;
  logic                    perr_out_q, ferr_out_q, overrun_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // Third sample is the live rxs in the decision cycle.
  assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
  assign decide  = (clk_cnt_q == CNT_DEC);
  assign bit_end = (clk_cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = bit_end ? '0 : clk_cnt_q + CNT_ONE;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    done       = 1'b0;
    word_ferr  = ferr_q;

    if (clk_cnt_q == CNT_S0) samp_d[0] = rxs;
    if (clk_cnt_q == CNT_S1) samp_d[1] = rxs;

    case (state_q)
      IDLE: begin
        clk_cnt_d  = '0;
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
        if (!rxs) begin
          state_d   = START;
          clk_cnt_d = CNT_ONE;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
        end
      end
      START: begin
        if (decide && vote) begin
          state_d   = IDLE;
          clk_cnt_d = '0;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (decide) shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
        if (bit_end) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
          end
        end
      end
      PAR: begin
        if (decide) perr_d = (^{shift_q, vote}) ^ ODD;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (decide) begin
          word_ferr = ferr_q | ~vote;
          ferr_d    = word_ferr;
          if (stop_cnt_q == STOP_LAST) begin
            done       = 1'b1;
            clk_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            state_d    = word_ferr ? RECOVER : IDLE;
          end
        end
        if (bit_end) stop_cnt_d = ~stop_cnt_q;
      end
      RECOVER: begin
        clk_cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        clk_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      samp_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      samp_q     <= samp_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  // A completing word may replace one being consumed in the same cycle.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (done && (!m_valid_q || m_ready)) begin
        m_valid_q  <= 1'b1;
        m_data_q   <= shift_q;
        perr_out_q <= perr_q;
        ferr_out_q <= word_ferr;
      end else begin
        if (done) overrun_q <= 1'b1;
        if (m_valid_q && m_ready) m_valid_q <= 1'b0;
      end
    end
  end

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 7E1, 8N2) driven with directed frames,
// checked against a frame-level word queue model plus literal expectations.
module tb_uart_rx_cfg;

  logic       clk = 1'b0;
  logic       arst;
  logic [2:0] rx, m_ready, m_valid, perr, ferr, ovr, busy;
  logic [7:0] md0, md2;
  logic [6:0] md1;
  logic [8:0] md_all [3];

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } word_t;

  word_t      expq [3][$];
  word_t      cmp_w;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         t_start = 0;
  int         seen    = 0;
  int         p0      = 0;
  int         obs_ovr [3] = '{0, 0, 0};
  int         exp_ovr [3] = '{0, 0, 0};
  int         npop    [3] = '{0, 0, 0};
  logic [8:0] last_data [3];
  logic       last_pe [3];
  logic       last_fe [3];

  uart_rx_cfg u0 (
    .clk(clk), .arst(arst), .rx(rx[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
    .m_data(md0), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]), .busy(busy[0])
  );

  uart_rx_cfg #(.DATA_WIDTH(7), .PARITY(2)) u1 (
    .clk(clk), .arst(arst), .rx(rx[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
    .m_data(md1), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]), .busy(busy[1])
  );

  uart_rx_cfg #(.STOP_BITS(2)) u2 (
    .clk(clk), .arst(arst), .rx(rx[2]), .m_valid(m_valid[2]), .m_ready(m_ready[2]),
    .m_data(md2), .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]), .busy(busy[2])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    md_all[0] = {1'b0, md0};
    md_all[1] = {2'b00, md1};
    md_all[2] = {1'b0, md2};
  end

  function automatic int dw_of(input int i);
    return (i == 1) ? 7 : 8;
  endfunction

  function automatic int par_of(input int i);
    return (i == 1) ? 2 : 0;
  endfunction

  function automatic int nstop_of(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ready(input int i, input logic v);
    @(posedge clk);
    #1;
    m_ready[i] = v;
  endtask

  // Builds the frame, predicts the delivered word (or a drop), then drives it one cell at a time.
  task automatic send_frame(input int i, input logic [8:0] data, input bit flip_par,
                            input bit [1:0] stop_vals, input bit jitter, input bit noise);
    bit    bits[$];
    word_t w;
    int    dw, len;
    bit    p, x;
    dw     = dw_of(i);
    w.data = '0;
    w.pe   = 1'b0;
    w.fe   = 1'b0;
    bits.push_back(1'b0);
    for (int b = 0; b < dw; b++) begin
      bits.push_back(data[b]);
      w.data[b] = data[b];
    end
    if (par_of(i) != 0) begin
      p = (^w.data) ^ (par_of(i) == 1) ^ flip_par;
      bits.push_back(p);
      x = (^w.data) ^ p;
      w.pe = (par_of(i) == 1) ? (x == 1'b0) : (x == 1'b1);
    end
    for (int s = 0; s < nstop_of(i); s++) begin
      bits.push_back(stop_vals[s]);
      if (!stop_vals[s]) w.fe = 1'b1;
    end
    if (expq[i].size() > 0 && !m_ready[i]) exp_ovr[i]++;
    else expq[i].push_back(w);
    for (int k = 0; k < bits.size(); k++) begin
      len = jitter ? ((k % 2 == 0) ? 17 : 15) : 16;
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        if (k == 0 && c == 0) t_start = cyc;
        rx[i] = (noise && k >= 1 && k <= dw && c == 8) ? ~bits[k] : bits[k];
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!arst) begin
        for (int i = 0; i < 3; i++) begin
          if (ovr[i]) obs_ovr[i]++;
          if (m_valid[i]) begin
            if (expq[i].size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL spurious_word inst%0d: got m_data %0h, required no word", i, md_all[i]);
            end else begin
              cmp_w = expq[i][0];
              chk($sformatf("m_data inst%0d", i), 32'(md_all[i]), 32'(cmp_w.data));
              chk($sformatf("parity_err inst%0d", i), 32'(perr[i]), 32'(cmp_w.pe));
              chk($sformatf("frame_err inst%0d", i), 32'(ferr[i]), 32'(cmp_w.fe));
              if (m_ready[i]) begin
                last_data[i] = md_all[i];
                last_pe[i]   = perr[i];
                last_fe[i]   = ferr[i];
                void'(expq[i].pop_front());
                npop[i]++;
              end
            end
          end
        end
      end
    end
  end

  initial begin
    arst    = 1'b1;
    rx      = '1;
    m_ready = '1;
    for (int i = 0; i < 3; i++) begin
      last_data[i] = '0;
      last_pe[i]   = 1'b0;
      last_fe[i]   = 1'b0;
    end
    cycles(3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset m_valid inst%0d", i), 32'(m_valid[i]), 32'd0);
      chk($sformatf("reset busy inst%0d", i), 32'(busy[i]), 32'd0);
      chk($sformatf("reset flags inst%0d", i), 32'({perr[i], ferr[i], ovr[i]}), 32'd0);
      chk($sformatf("reset m_data inst%0d", i), 32'(md_all[i]), 32'd0);
    end
    arst = 1'b0;
    cycles(5);

    // 8N1 0xA5, latency from rx start edge to m_valid, single-cycle valid under m_ready
    fork
      send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b0, 1'b0);
      begin
        seen = -1;
        for (int c = 0; c < 400; c++) begin
          @(negedge clk);
          if (m_valid[0]) begin
            seen = cyc;
            break;
          end
        end
        chk("t1 latency", 32'(seen - t_start), 32'd156);
        @(negedge clk);
        chk("t1 valid one cycle", 32'(m_valid[0]), 32'd0);
      end
    join
    chk("t1 data", 32'(last_data[0]), 32'h0A5);
    chk("t1 flags", 32'({last_pe[0], last_fe[0]}), 32'd0);
    cycles(10);

    // start glitch of 3 clk
    @(negedge clk);
    rx[0] = 1'b0;
    cycles(3);
    rx[0] = 1'b1;
    cycles(2);
    chk("t2 busy during start", 32'(busy[0]), 32'd1);
    cycles(15);
    chk("t2 busy after glitch", 32'(busy[0]), 32'd0);
    send_frame(0, 9'h03C, 1'b0, 2'b11, 1'b0, 1'b0);
    chk("t2 data", 32'(last_data[0]), 32'h03C);
    cycles(10);

    // 7E1 parity
    send_frame(1, 9'h055, 1'b0, 2'b11, 1'b0, 1'b0);
    chk("t3 good data", 32'(last_data[1]), 32'h055);
    chk("t3 good parity", 32'(last_pe[1]), 32'd0);
    cycles(5);
    send_frame(1, 9'h055, 1'b1, 2'b11, 1'b0, 1'b0);
    chk("t3 bad data", 32'(last_data[1]), 32'h055);
    chk("t3 bad parity", 32'(last_pe[1]), 32'd1);
    chk("t3 bad frame", 32'(last_fe[1]), 32'd0);
    cycles(10);

    // 8N2 second stop low, line held low
    send_frame(2, 9'h0C3, 1'b0, 2'b01, 1'b0, 1'b0);
    cycles(40);
    chk("t4 recover busy", 32'(busy[2]), 32'd1);
    chk("t4 frame_err", 32'(last_fe[2]), 32'd1);
    chk("t4 data", 32'(last_data[2]), 32'h0C3);
    rx[2] = 1'b1;
    cycles(6);
    chk("t4 idle after high", 32'(busy[2]), 32'd0);
    send_frame(2, 9'h00F, 1'b0, 2'b11, 1'b0, 1'b0);
    chk("t4 next data", 32'(last_data[2]), 32'h00F);
    chk("t4 next frame_err", 32'(last_fe[2]), 32'd0);
    cycles(10);

    // backpressure and overrun
    set_ready(0, 1'b0);
    send_frame(0, 9'h011, 1'b0, 2'b11, 1'b0, 1'b0);
    cycles(5);
    send_frame(0, 9'h022, 1'b0, 2'b11, 1'b0, 1'b0);
    cycles(5);
    chk("t5 held data", 32'(md0), 32'h11);
    chk("t5 held valid", 32'(m_valid[0]), 32'd1);
    chk("t5 overrun pulses", 32'(obs_ovr[0]), 32'd1);
    set_ready(0, 1'b1);
    cycles(3);
    chk("t5 valid cleared", 32'(m_valid[0]), 32'd0);
    chk("t5 consumed data", 32'(last_data[0]), 32'h011);
    cycles(10);

    // zero-gap frames with jitter and mid-bit noise
    p0 = npop[0];
    send_frame(0, 9'h000, 1'b0, 2'b11, 1'b1, 1'b1);
    send_frame(0, 9'h0FF, 1'b0, 2'b11, 1'b1, 1'b1);
    send_frame(0, 9'h096, 1'b0, 2'b11, 1'b1, 1'b1);
    send_frame(0, 9'h03C, 1'b0, 2'b11, 1'b1, 1'b1);
    cycles(5);
    chk("t6 words received", 32'(npop[0] - p0), 32'd4);
    chk("t6 last data", 32'(last_data[0]), 32'h03C);
    cycles(10);

    // reset mid-DATA with a held word
    set_ready(0, 1'b0);
    send_frame(0, 9'h05A, 1'b0, 2'b11, 1'b0, 1'b0);
    cycles(5);
    @(negedge clk);
    rx[0] = 1'b0;
    cycles(16);
    rx[0] = 1'b1;
    cycles(40);
    chk("t7 busy before reset", 32'(busy[0]), 32'd1);
    @(negedge clk);
    #2;
    arst = 1'b1;
    rx   = '1;
    for (int i = 0; i < 3; i++) expq[i].delete();
    @(posedge clk);
    #1;
    chk("t7 m_valid", 32'(m_valid[0]), 32'd0);
    chk("t7 m_data", 32'(md0), 32'd0);
    chk("t7 flags", 32'({perr[0], ferr[0], ovr[0]}), 32'd0);
    chk("t7 busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    arst = 1'b0;
    cycles(10);
    set_ready(0, 1'b1);
    send_frame(0, 9'h081, 1'b0, 2'b11, 1'b0, 1'b0);
    chk("t7 data after reset", 32'(last_data[0]), 32'h081);
    cycles(20);

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("undelivered words inst%0d", i), 32'(expq[i].size()), 32'd0);
      chk($sformatf("overrun count inst%0d", i), 32'(obs_ovr[i]), 32'(exp_ovr[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
